// File: rtl/can_pkg.sv
// Shared types for the CAN receive frame path: frame entry layout and assembly states.
package can_pkg;

   localparam int CAN_ID_W    = 29;
   localparam int MAX_PAYLOAD = 8;
   localparam int LEN_W       = 4;

   typedef struct packed {
      logic [CAN_ID_W-1:0]      id;
      logic                     ide;
      logic [LEN_W-1:0]         len;
      logic                     trunc;
      logic [8*MAX_PAYLOAD-1:0] data;
   } can_frame_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } asm_state_t;

endpackage

// File: rtl/can_frame_fifo.sv
// Generic first-word-fall-through FIFO; head is visible the cycle after the write.
// A write is accepted when not full or when a read happens on the same edge.
module can_frame_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_wr_vld,
   input  logic [WIDTH-1:0]           i_wr_dat,
   input  logic                       i_rd_rdy,
   output logic [WIDTH-1:0]           o_rd_dat,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_wr;
   logic             w_rd;

   // Extra pointer bit: equal low bits with differing MSB means full.
   assign o_empty  = (r_wr_ptr == r_rd_ptr);
   assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_rd     = i_rd_rdy & ~o_empty;
   assign w_wr     = i_wr_vld & (~o_full | w_rd);
   assign o_rd_dat = r_mem[r_rd_ptr[AW-1:0]];
   assign o_level  = LW'(r_wr_ptr - r_rd_ptr);

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/can_rx_frame_fifo.sv
// Assembles the can_top byte stream into frames and queues them for the AXI controller.
// Frame visible one cycle after can_rx_last; frames arriving to a full queue are dropped and counted.
module can_rx_frame_fifo
   import can_pkg::*;
#(
   parameter int MAX_BYTES  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                            ap_clk,
   input  logic                            ap_rst_n,
   input  logic [7:0]                      can_rx_data,
   input  logic [CAN_ID_W-1:0]             can_rx_id,
   input  logic                            can_rx_ide,
   input  logic                            can_rx_valid,
   input  logic                            can_rx_last,
   output logic                            frm_valid,
   input  logic                            frm_ready,
   output logic [CAN_ID_W-1:0]             frm_id,
   output logic                            frm_ide,
   output logic [LEN_W-1:0]                frm_len,
   output logic                            frm_trunc,
   output logic [8*MAX_BYTES-1:0]          frm_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
   output logic                            overflow,
   input  logic                            overflow_clr,
   output logic [7:0]                      drop_cnt,
   input  logic                            int_en,
   output logic                            int_wire
);

   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BYTES);

   asm_state_t          r_state;
   asm_state_t          w_state_nxt;
   logic [CAN_ID_W-1:0] r_id;
   logic                r_ide;
   logic [LEN_W-1:0]    r_cnt;
   logic                r_trunc;
   logic [7:0]          r_bytes [MAX_BYTES];
   logic [7:0]          w_bytes [MAX_BYTES];
   logic                w_append;
   logic [LEN_W-1:0]    w_base;
   logic [LEN_W-1:0]    w_len;
   logic                w_trunc;
   logic                w_commit;
   can_frame_t          w_entry;
   can_frame_t          w_rd_dat;
   can_frame_t          w_head;
   logic                w_full;
   logic                w_empty;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic                r_overflow;
   logic [7:0]          r_drop_cnt;
   logic                r_int;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) r_state <= ST_IDLE;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (can_rx_valid && !can_rx_last) w_state_nxt = ST_COLLECT;
         ST_COLLECT: if (can_rx_last) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Frame under construction including the current beat, so a commit needs no extra cycle.
   always_comb begin
      w_base   = (r_state == ST_IDLE) ? '0 : r_cnt;
      w_append = can_rx_valid && (w_base < MAX_L);
      w_len    = w_base + LEN_W'(w_append);
      w_trunc  = (r_state == ST_COLLECT) && (r_trunc || (can_rx_valid && !(r_cnt < MAX_L)));
      w_commit = can_rx_last;
      for (int k = 0; k < MAX_BYTES; k++) begin
         w_bytes[k] = r_bytes[k];
         if (w_append && (w_base == LEN_W'(k))) w_bytes[k] = can_rx_data;
      end
      w_entry       = '0;
      w_entry.id    = (r_state == ST_IDLE) ? can_rx_id  : r_id;
      w_entry.ide   = (r_state == ST_IDLE) ? can_rx_ide : r_ide;
      w_entry.len   = w_len;
      w_entry.trunc = w_trunc;
      for (int k = 0; k < MAX_BYTES; k++) begin
         for (int i = 0; i < MAX_BYTES; i++) begin
            if (MSB_FIRST ? (LEN_W'(k + i + 1) == w_len) : ((k == i) && (LEN_W'(i) < w_len)))
               w_entry.data[8*k +: 8] = w_bytes[i];
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_id    <= '0;
         r_ide   <= 1'b0;
         r_cnt   <= '0;
         r_trunc <= 1'b0;
         for (int k = 0; k < MAX_BYTES; k++) r_bytes[k] <= '0;
      end else if (w_state_nxt == ST_COLLECT) begin
         if (r_state == ST_IDLE) begin
            r_id  <= can_rx_id;
            r_ide <= can_rx_ide;
         end
         r_cnt   <= w_len;
         r_trunc <= w_trunc;
         for (int k = 0; k < MAX_BYTES; k++) r_bytes[k] <= w_bytes[k];
      end
   end

   assign w_pop  = frm_valid & frm_ready;
   assign w_push = w_commit & (~w_full | w_pop);
   assign w_drop = w_commit & ~w_push;

   can_frame_fifo #(
      .WIDTH ($bits(can_frame_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk    (ap_clk),
      .i_rst_n  (ap_rst_n),
      .i_wr_vld (w_push),
      .i_wr_dat (w_entry),
      .i_rd_rdy (w_pop),
      .o_rd_dat (w_rd_dat),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_level  (fifo_level)
   );

   // Head fields read as zero when nothing is queued.
   assign w_head    = w_empty ? '0 : w_rd_dat;
   assign frm_valid = ~w_empty;
   assign frm_id    = w_head.id;
   assign frm_ide   = w_head.ide;
   assign frm_len   = w_head.len;
   assign frm_trunc = w_head.trunc;
   assign frm_data  = w_head.data[8*MAX_BYTES-1:0];

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
         r_int      <= 1'b0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= overflow_clr ? 8'd1 : ((r_drop_cnt == 8'hFF) ? 8'hFF : r_drop_cnt + 8'd1);
         end else if (overflow_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
         end
         r_int <= int_en & (frm_valid | r_overflow);
      end
   end

   assign overflow = r_overflow;
   assign drop_cnt = r_drop_cnt;
   assign int_wire = r_int;

endmodule

// File: tb/tb_can_rx_frame_fifo.sv
// Drives directed and random frames into two instances (MSB_FIRST 1 and 0) and compares against a queue-based frame model.
module tb_can_rx_frame_fifo;

   localparam int MB    = 8;
   localparam int DEPTH = 4;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic [7:0]  can_rx_data = '0;
   logic [28:0] can_rx_id = '0;
   logic        can_rx_ide = 1'b0;
   logic        can_rx_valid = 1'b0;
   logic        can_rx_last = 1'b0;
   logic        frm_ready = 1'b0;
   logic        overflow_clr = 1'b0;
   logic        int_en = 1'b0;

   logic        frm_valid, frm_ide, frm_trunc, overflow, int_wire;
   logic [28:0] frm_id;
   logic [3:0]  frm_len;
   logic [63:0] frm_data;
   logic [2:0]  fifo_level;
   logic [7:0]  drop_cnt;

   logic        frm_valid0, frm_ide0, frm_trunc0, overflow0, int_wire0;
   logic [28:0] frm_id0;
   logic [3:0]  frm_len0;
   logic [63:0] frm_data0;
   logic [2:0]  fifo_level0;
   logic [7:0]  drop_cnt0;

   always #5 ap_clk = ~ap_clk;

   can_rx_frame_fifo #(.MAX_BYTES(MB), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .can_rx_data(can_rx_data), .can_rx_id(can_rx_id),
      .can_rx_ide(can_rx_ide), .can_rx_valid(can_rx_valid), .can_rx_last(can_rx_last),
      .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_id(frm_id), .frm_ide(frm_ide),
      .frm_len(frm_len), .frm_trunc(frm_trunc), .frm_data(frm_data), .fifo_level(fifo_level),
      .overflow(overflow), .overflow_clr(overflow_clr), .drop_cnt(drop_cnt),
      .int_en(int_en), .int_wire(int_wire));

   can_rx_frame_fifo #(.MAX_BYTES(MB), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_dut0 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .can_rx_data(can_rx_data), .can_rx_id(can_rx_id),
      .can_rx_ide(can_rx_ide), .can_rx_valid(can_rx_valid), .can_rx_last(can_rx_last),
      .frm_valid(frm_valid0), .frm_ready(frm_ready), .frm_id(frm_id0), .frm_ide(frm_ide0),
      .frm_len(frm_len0), .frm_trunc(frm_trunc0), .frm_data(frm_data0), .fifo_level(fifo_level0),
      .overflow(overflow0), .overflow_clr(overflow_clr), .drop_cnt(drop_cnt0),
      .int_en(int_en), .int_wire(int_wire0));

   typedef struct {
      logic [28:0] id;
      logic        ide;
      int          len;
      logic        trunc;
      logic [63:0] d1;
      logic [63:0] d0;
   } exp_t;

   exp_t        mq[$];
   bit          m_ovf;
   int          m_drop;
   bit          m_int;
   byte unsigned tx[$];
   int          checks = 0;
   int          errors = 0;
   bit          rnd_rdy, rnd_clr, rnd_int, auto_chk;

   // Expected entry straight from the byte list: first MB bytes kept, placed per lane order.
   function automatic exp_t mk(logic [28:0] id, logic ide);
      exp_t e;
      int   n = tx.size();
      e.id    = id;
      e.ide   = ide;
      e.len   = (n > MB) ? MB : n;
      e.trunc = (n > MB);
      e.d1    = '0;
      e.d0    = '0;
      for (int i = 0; i < e.len; i++) begin
         e.d0[8*i +: 8]             = tx[i];
         e.d1[8*(e.len-1-i) +: 8]   = tx[i];
      end
      return e;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      exp_t h;
      bit   v = (mq.size() > 0);
      if (v) h = mq[0];
      else begin
         h.id = '0; h.ide = 1'b0; h.len = 0; h.trunc = 1'b0; h.d1 = '0; h.d0 = '0;
      end
      chk({tag, ".valid"}, 64'(frm_valid), 64'(v));
      chk({tag, ".level"}, 64'(fifo_level), 64'(mq.size()));
      chk({tag, ".ovf"},   64'(overflow), 64'(m_ovf));
      chk({tag, ".drop"},  64'(drop_cnt), 64'(m_drop));
      chk({tag, ".int"},   64'(int_wire), 64'(m_int));
      chk({tag, ".id"},    64'(frm_id), 64'(h.id));
      chk({tag, ".ide"},   64'(frm_ide), 64'(h.ide));
      chk({tag, ".len"},   64'(frm_len), 64'(h.len));
      chk({tag, ".trunc"}, 64'(frm_trunc), 64'(h.trunc));
      chk({tag, ".data"},  frm_data, h.d1);
      chk({tag, ".valid0"}, 64'(frm_valid0), 64'(v));
      chk({tag, ".level0"}, 64'(fifo_level0), 64'(mq.size()));
      chk({tag, ".ovf0"},   64'(overflow0), 64'(m_ovf));
      chk({tag, ".drop0"},  64'(drop_cnt0), 64'(m_drop));
      chk({tag, ".int0"},   64'(int_wire0), 64'(m_int));
      chk({tag, ".id0"},    64'(frm_id0), 64'(h.id));
      chk({tag, ".ide0"},   64'(frm_ide0), 64'(h.ide));
      chk({tag, ".len0"},   64'(frm_len0), 64'(h.len));
      chk({tag, ".trunc0"}, 64'(frm_trunc0), 64'(h.trunc));
      chk({tag, ".data0"},  frm_data0, h.d0);
   endtask

   // One clock: update the model for what this cycle's inputs do, then cross the edge.
   task automatic step(input bit commit, input exp_t e);
      bit pop;
      bit int_n;
      if (rnd_rdy) frm_ready    = ($urandom_range(0, 3) == 0);
      if (rnd_clr) overflow_clr = ($urandom_range(0, 7) == 0);
      if (rnd_int) int_en       = $urandom_range(0, 1);
      pop   = frm_ready && (mq.size() > 0);
      int_n = int_en && ((mq.size() > 0) || m_ovf);
      if (pop) void'(mq.pop_front());
      if (commit && (mq.size() < DEPTH)) mq.push_back(e);
      else if (commit) begin
         m_ovf  = 1'b1;
         m_drop = overflow_clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
      end else if (overflow_clr) begin
         m_ovf  = 1'b0;
         m_drop = 0;
      end
      m_int = int_n;
      @(posedge ap_clk);
      #1;
      if (auto_chk) check_all("rnd");
   endtask

   task automatic idle(input int n);
      exp_t e;
      e = mk(29'd0, 1'b0);
      can_rx_valid = 1'b0;
      can_rx_last  = 1'b0;
      for (int k = 0; k < n; k++) begin
         can_rx_id = 29'($urandom);
         step(1'b0, e);
      end
   endtask

   // Sends the bytes in tx; ID is only meaningful on the first beat, so it is scrambled afterwards.
   task automatic send(input logic [28:0] id, input logic ide, input bit gaps, input bit pop_last);
      exp_t e;
      int   n = tx.size();
      e = mk(id, ide);
      if (n == 0) begin
         can_rx_id = id; can_rx_ide = ide; can_rx_valid = 1'b0; can_rx_last = 1'b1;
         if (pop_last) frm_ready = 1'b1;
         step(1'b1, e);
      end else begin
         for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
               can_rx_valid = 1'b0;
               can_rx_last  = 1'b0;
               repeat ($urandom_range(0, 2)) step(1'b0, e);
            end
            can_rx_valid = 1'b1;
            can_rx_data  = tx[i];
            can_rx_last  = (i == n - 1);
            can_rx_id    = (i == 0) ? id  : 29'($urandom);
            can_rx_ide   = (i == 0) ? ide : 1'($urandom);
            if (pop_last && i == n - 1) frm_ready = 1'b1;
            step(i == n - 1, e);
         end
      end
      can_rx_valid = 1'b0;
      can_rx_last  = 1'b0;
      if (pop_last) frm_ready = 1'b0;
   endtask

   task automatic pop_one(input string tag);
      exp_t e;
      e = mk(29'd0, 1'b0);
      check_all(tag);
      frm_ready = 1'b1;
      step(1'b0, e);
      frm_ready = 1'b0;
   endtask

   task automatic rand_bytes(input int n);
      tx.delete();
      for (int i = 0; i < n; i++) tx.push_back(byte'($urandom));
   endtask

   initial begin
      exp_t dummy;
      m_ovf = 0; m_drop = 0; m_int = 0;
      rnd_rdy = 0; rnd_clr = 0; rnd_int = 0; auto_chk = 0;
      repeat (3) @(negedge ap_clk);
      #1 check_all("reset");
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;

      // Four-byte frame, MSB-first lane order.
      tx = '{8'h11, 8'h22, 8'h33, 8'h44};
      send(29'h003, 1'b0, 1'b0, 1'b0);
      check_all("four");
      chk("four.data_const", frm_data, 64'h0000_0000_1122_3344);
      pop_one("four.head");
      check_all("four.popped");

      // Ten-byte frame truncated to eight.
      tx.delete();
      for (int i = 1; i <= 10; i++) tx.push_back(byte'(i));
      send(29'h1ABCDEF, 1'b1, 1'b1, 1'b0);
      check_all("trunc");
      chk("trunc.data0_const", frm_data0, 64'h0807_0605_0403_0201);
      chk("trunc.flag_const", 64'(frm_trunc0), 64'd1);
      pop_one("trunc.head");

      // Overflow: five frames into a four-deep queue.
      int_en = 1'b1;
      for (int f = 0; f < 5; f++) begin
         rand_bytes($urandom_range(1, 8));
         send(29'($urandom), 1'($urandom), 1'b1, 1'b0);
         check_all("fill");
      end
      chk("ovf.drop_const", 64'(drop_cnt), 64'd1);
      idle(1);
      check_all("ovf.int");
      for (int f = 0; f < 4; f++) pop_one("ovf.drain");
      check_all("ovf.empty");
      overflow_clr = 1'b1;
      idle(1);
      overflow_clr = 1'b0;
      check_all("ovf.clr");

      // Commit into a full queue on the same edge as a pop.
      for (int f = 0; f < 4; f++) begin
         rand_bytes($urandom_range(1, 8));
         send(29'($urandom), 1'($urandom), 1'b0, 1'b0);
      end
      rand_bytes(3);
      send(29'h0777, 1'b0, 1'b0, 1'b1);
      check_all("popfull");
      chk("popfull.level_const", 64'(fifo_level), 64'd4);
      for (int f = 0; f < 4; f++) pop_one("popfull.drain");

      // Zero-length frame.
      tx.delete();
      send(29'h12345678, 1'b1, 1'b0, 1'b0);
      check_all("zero");
      chk("zero.id_const", 64'(frm_id), 64'h12345678);
      pop_one("zero.head");

      // Asynchronous reset in the middle of a frame with two frames queued.
      for (int f = 0; f < 2; f++) begin
         rand_bytes(4);
         send(29'($urandom), 1'b0, 1'b0, 1'b0);
      end
      dummy = mk(29'd0, 1'b0);
      can_rx_id = 29'h055;
      for (int i = 0; i < 3; i++) begin
         can_rx_valid = 1'b1;
         can_rx_data  = byte'($urandom);
         step(1'b0, dummy);
      end
      can_rx_valid = 1'b0;
      #2 ap_rst_n = 1'b0;
      mq.delete(); m_ovf = 0; m_drop = 0; m_int = 0;
      #1 check_all("arst");
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      tx = '{8'hA5, 8'h5A};
      send(29'h0321, 1'b0, 1'b0, 1'b0);
      check_all("post_rst");
      pop_one("post_rst.head");

      // Random traffic with random consumer, clear and interrupt enable.
      auto_chk = 1; rnd_rdy = 1; rnd_clr = 1; rnd_int = 1;
      for (int f = 0; f < 60; f++) begin
         rand_bytes($urandom_range(0, 11));
         send(29'($urandom), 1'($urandom), 1'b1, 1'b0);
         idle($urandom_range(0, 3));
      end
      rnd_rdy = 0; rnd_clr = 0; rnd_int = 0;
      frm_ready = 1'b1;
      idle(DEPTH + 1);
      frm_ready = 1'b0;
      auto_chk = 0;
      check_all("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
